seg_scan_capture: RTL and testbench

Receive side of the multiplexed 4-digit 7-segment scan bus. Samples the active-low digit-select and segment lines and decodes each glyph back to a hex nibble. Reconstructs the 4-digit value and flags malformed scans. Used as a display read-back and self-check monitor alongside the display scan driver.

---
 rtl/seg_scan_capture.sv | 218 +++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of the multiplexed 4-digit 7-segment scan bus.
// Samples the active-low select/segment lines. Once a pair has been stable long
// enough it decodes the glyph back to a hex nibble, rebuilds the 4-digit value,
// tracks scan order and raises sticky flags for malformed scans.
//
// Handshake: there is no valid/ready pair on this block. A capture is a
// single-cycle internal event (cap_q) raised one cycle before the outputs
// change. o_frameValid is a one-cycle pulse, qualified by nothing else, in the
// same cycle that digit 3 appears on o_digits.
module seg_scan_capture #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_digitSelect,
  input  logic [6:0]  i_seg,
  input  logic        i_clrErr,
  output logic [15:0] o_digits,
  output logic [3:0]  o_digitValid,
  output logic        o_frameValid,
  output logic        o_badSelect,
  output logic        o_badPattern,
  output logic        o_seqErr,
  output logic        o_stale
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);

  // Sequence tracker: HUNT waits for digit 0, EXPn expects digit n next.
  typedef enum logic [1:0] {HUNT, EXP1, EXP2, EXP3} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sel_q;
  logic [6:0]      seg_q;
  logic [CW-1:0]   stab_q, stab_d;
  logic            cap_q, cap_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [15:0]     digits_q, digits_d;
  logic [3:0]      dv_q, dv_d;
  logic            fv_q, fv_d;
  logic            bsel_q, bsel_d;
  logic            bpat_q, bpat_d;
  logic            seq_q, seq_d;
  logic            stale_q, stale_d;

  logic [1:0]      k;
  logic            sel_ok;
  logic            sel_blank;
  logic [3:0]      nib;
  logic            glyph_hit;
  logic            good_cap;
  logic            bad_sel_ev;
  logic            bad_pat_ev;
  logic            seq_err;

  // Stability counter: counts repeated samples, fires capture once per stable run.
  always_comb begin
    stab_d = '0;
    if ({i_digitSelect, i_seg} == {sel_q, seg_q}) begin
      stab_d = (stab_q == SETTLE_C) ? stab_q : stab_q + 1'b1;
    end
    cap_d = (stab_d == SETTLE_C) && (stab_q != SETTLE_C);
  end

  // Input stage: register the raw bus and the stability state every edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q  <= 4'hF;
      seg_q  <= 7'h7F;
      stab_q <= '0;
      cap_q  <= 1'b0;
    end else begin
      sel_q  <= i_digitSelect;
      seg_q  <= i_seg;
      stab_q <= stab_d;
      cap_q  <= cap_d;
    end
  end

  // Select decode: one-cold gives the digit index, all-high is a blank slot.
  always_comb begin
    k         = 2'd0;
    sel_ok    = 1'b1;
    sel_blank = 1'b0;
    case (sel_q)
      4'b1110: k = 2'd0;
      4'b1101: k = 2'd1;
      4'b1011: k = 2'd2;
      4'b0111: k = 2'd3;
      4'b1111: begin
        sel_ok    = 1'b0;
        sel_blank = 1'b1;
      end
      default: sel_ok = 1'b0;
    endcase
  end

  // Glyph decode: active-high gfedcba pattern back to a hex nibble.
  always_comb begin
    nib       = 4'h0;
    glyph_hit = 1'b1;
    case (~seg_q)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: glyph_hit = 1'b0;
    endcase
  end

  assign good_cap   = cap_q && sel_ok && glyph_hit;
  assign bad_sel_ev = cap_q && !sel_ok && !sel_blank;
  assign bad_pat_ev = cap_q && sel_ok && !glyph_hit;

  // Next-state: digit store, scan-order FSM, timeout and sticky flags.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    dv_d     = dv_q;
    fv_d     = 1'b0;
    stale_d  = stale_q;
    seq_err  = 1'b0;
    tmo_d    = tmo_q;

    if (good_cap) begin
      tmo_d = '0;
    end else if (tmo_q != TIMEOUT_C) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (good_cap) begin
      digits_d[{k, 2'b00} +: 4] = nib;
      dv_d[k]                   = 1'b1;
      stale_d                   = 1'b0;
      case (state_q)
        HUNT: if (k == 2'd0) state_d = EXP1;
        EXP1: begin
          if (k == 2'd1) state_d = EXP2;
          else if (k == 2'd0) begin state_d = EXP1; seq_err = 1'b1; end
          else begin state_d = HUNT; seq_err = 1'b1; end
        end
        EXP2: begin
          if (k == 2'd2) state_d = EXP3;
          else if (k == 2'd0) begin state_d = EXP1; seq_err = 1'b1; end
          else begin state_d = HUNT; seq_err = 1'b1; end
        end
        EXP3: begin
          if (k == 2'd3) begin state_d = HUNT; fv_d = 1'b1; end
          else if (k == 2'd0) begin state_d = EXP1; seq_err = 1'b1; end
          else begin state_d = HUNT; seq_err = 1'b1; end
        end
        default: state_d = HUNT;
      endcase
    end

    // Timeout forgets which digits are current but keeps their values.
    if (tmo_d == TIMEOUT_C) begin
      stale_d = 1'b1;
      dv_d    = 4'h0;
      state_d = HUNT;
    end

    // A new error in the clearing cycle wins over the clear.
    bsel_d = (bsel_q & ~i_clrErr) | bad_sel_ev;
    bpat_d = (bpat_q & ~i_clrErr) | bad_pat_ev;
    seq_d  = (seq_q  & ~i_clrErr) | seq_err;
  end

  // Output and FSM state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= HUNT;
      tmo_q    <= '0;
      digits_q <= 16'h0000;
      dv_q     <= 4'h0;
      fv_q     <= 1'b0;
      bsel_q   <= 1'b0;
      bpat_q   <= 1'b0;
      seq_q    <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      digits_q <= digits_d;
      dv_q     <= dv_d;
      fv_q     <= fv_d;
      bsel_q   <= bsel_d;
      bpat_q   <= bpat_d;
      seq_q    <= seq_d;
      stale_q  <= stale_d;
    end
  end

  assign o_digits     = digits_q;
  assign o_digitValid = dv_q;
  assign o_frameValid = fv_q;
  assign o_badSelect  = bsel_q;
  assign o_badPattern = bpat_q;
  assign o_seqErr     = seq_q;
  assign o_stale      = stale_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture. The whole stimulus list (held select/segment
// pairs) is built first and run through a hold-level reference model that
// predicts every change of the output vector together with the cycle it
// appears in. The driver then plays the list and a negedge monitor pops one
// expectation per observed output change.
module tb_seg_scan_capture;

  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 1024;
  localparam int R       = 5;    // index of the last clock edge with reset high

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [6:0]  seg;
  logic        clr;
  logic [15:0] o_digits;
  logic [3:0]  o_digitValid;
  logic        o_frameValid, o_badSelect, o_badPattern, o_seqErr, o_stale;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_digitSelect(sel), .i_seg(seg), .i_clrErr(clr),
    .o_digits(o_digits), .o_digitValid(o_digitValid), .o_frameValid(o_frameValid),
    .o_badSelect(o_badSelect), .o_badPattern(o_badPattern), .o_seqErr(o_seqErr),
    .o_stale(o_stale)
  );

  // ---------------- stimulus list ----------------
  logic [3:0] s_sel[$];
  logic [6:0] s_seg[$];
  int         s_h[$];
  bit         s_clr[$];
  logic [10:0] prev_pair = 11'h7FF;

  int tests = 0;
  int fails = 0;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'h3F;  1: glyph = 7'h06;  2: glyph = 7'h5B;  3: glyph = 7'h4F;
      4: glyph = 7'h66;  5: glyph = 7'h6D;  6: glyph = 7'h7D;  7: glyph = 7'h07;
      8: glyph = 7'h7F;  9: glyph = 7'h6F; 10: glyph = 7'h77; 11: glyph = 7'h7C;
      12: glyph = 7'h39; 13: glyph = 7'h5E; 14: glyph = 7'h79; 15: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] gs(input int n);
    gs = ~glyph(n);
  endfunction

  // Consecutive holds must differ, otherwise they would merge into one hold.
  task automatic add_hold(input logic [3:0] a_sel, input logic [6:0] a_seg,
                          input int h, input bit c);
    logic [6:0] sg;
    sg = a_seg;
    if ({a_sel, sg} == prev_pair) sg = sg ^ 7'h40;
    s_sel.push_back(a_sel);
    s_seg.push_back(sg);
    s_h.push_back(h);
    s_clr.push_back(c);
    prev_pair = {a_sel, sg};
  endtask

  // ---------------- reference model ----------------
  logic [56:0] exp_q[$];          // {cycle[31:0], output vector[24:0]}
  logic [15:0] m_dig;
  logic [3:0]  m_dv;
  logic        m_fv, m_bsel, m_bpat, m_seq, m_stale;
  int          m_exp;             // 0: waiting for digit 0, n: digit n expected next
  int          lv, cur_t, bsel_t, bpat_t, seq_t, t_end;
  logic [24:0] last_vec;

  // Close out cycle cur_t: apply a pending timeout, record any output change.
  task automatic finish_cycle();
    logic [24:0] v;
    if (cur_t - lv >= TIMEOUT) begin
      m_stale = 1'b1;
      m_dv    = 4'h0;
      m_exp   = 0;
    end
    v = {m_fv, m_bsel, m_bpat, m_seq, m_stale, m_dv, m_dig};
    if (v != last_vec) begin
      exp_q.push_back({32'(cur_t), v});
      last_vec = v;
    end
  endtask

  task automatic adv(input int t);
    while (cur_t < t) begin
      finish_cycle();
      cur_t++;
      m_fv = 1'b0;
    end
  endtask

  task automatic m_clear(input int t);
    adv(t);
    if (bsel_t != t) m_bsel = 1'b0;
    if (bpat_t != t) m_bpat = 1'b0;
    if (seq_t  != t) m_seq  = 1'b0;
  endtask

  task automatic m_cap(input int t, input logic [3:0] a_sel, input logic [6:0] a_seg);
    int k;
    int nib;
    adv(t);
    k = -1;
    case (a_sel)
      4'b1110: k = 0;
      4'b1101: k = 1;
      4'b1011: k = 2;
      4'b0111: k = 3;
      default: k = -1;
    endcase
    if (a_sel == 4'b1111) return;
    if (k < 0) begin
      m_bsel = 1'b1;
      bsel_t = t;
      return;
    end
    nib = -1;
    for (int n = 0; n < 16; n++) if (glyph(n) == ~a_seg) nib = n;
    if (nib < 0) begin
      m_bpat = 1'b1;
      bpat_t = t;
      return;
    end
    m_dig[4*k +: 4] = nib[3:0];
    m_dv[k] = 1'b1;
    m_stale = 1'b0;
    lv = t;
    if (m_exp == 0) begin
      if (k == 0) m_exp = 1;
    end else if (k == m_exp) begin
      if (k == 3) begin m_fv = 1'b1; m_exp = 0; end
      else m_exp = k + 1;
    end else if (k == 0) begin
      m_exp = 1; m_seq = 1'b1; seq_t = t;
    end else begin
      m_exp = 0; m_seq = 1'b1; seq_t = t;
    end
  endtask

  // A pair first sampled at edge e0 and held h edges is captured when it
  // covers SETTLE+1 edges; the outputs move at edge e0+SETTLE+1.
  task automatic run_model();
    int e0;
    m_dig = '0; m_dv = '0; m_fv = 0; m_bsel = 0; m_bpat = 0; m_seq = 0; m_stale = 0;
    m_exp = 0; lv = R; cur_t = R; bsel_t = -1; bpat_t = -1; seq_t = -1;
    last_vec = '0;
    e0 = R + 1;
    for (int i = 0; i < s_h.size(); i++) begin
      if (s_clr[i]) m_clear(e0);
      if (s_h[i] >= SETTLE + 1) m_cap(e0 + SETTLE + 1, s_sel[i], s_seg[i]);
      e0 += s_h[i];
    end
    t_end = e0 - 1;
    adv(t_end);
    finish_cycle();
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          mon_en = 1'b0;
  logic [24:0] last_seen = '0;

  always @(negedge clk) begin
    logic [24:0] v;
    logic [56:0] e;
    if (mon_en) begin
      v = {o_frameValid, o_badSelect, o_badPattern, o_seqErr, o_stale, o_digitValid, o_digits};
      if (v !== last_seen) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_change cyc %0d: got %h, expected no change", cyc, v);
        end else begin
          e = exp_q.pop_front();
          if (int'(e[56:25]) != cyc || e[24:0] !== v) begin
            fails++;
            $display("FAIL out_change: got %h at cyc %0d, expected %h at cyc %0d",
                     v, cyc, e[24:0], int'(e[56:25]));
          end
        end
        last_seen = v;
      end
    end
  end

  // ---------------- stimulus build, drive, report ----------------
  initial begin
    int nk;
    int r;
    logic [3:0] rs;
    rst = 1'b1; sel = 4'hF; seg = 7'h7F; clr = 1'b0;

    // Idle blank period straight after reset.
    add_hold(4'hF, 7'h7F, 10, 1'b0);
    // Clean in-order frame 1,2,3,4.
    add_hold(4'b1110, gs(1), 4, 1'b0);
    add_hold(4'b1101, gs(2), 4, 1'b0);
    add_hold(4'b1011, gs(3), 4, 1'b0);
    add_hold(4'b0111, gs(4), 4, 1'b0);
    // Settle boundary: 2-edge hold ignored, 3-edge hold captured.
    add_hold(4'b1110, gs(8), 2, 1'b0);
    add_hold(4'hF, 7'h7F, 1, 1'b0);
    add_hold(4'b1110, gs(8), 3, 1'b0);
    add_hold(4'hF, 7'h7F, 4, 1'b0);
    // Bad select, clear, bad pattern, clear.
    add_hold(4'b1100, gs(5), 4, 1'b0);
    add_hold(4'hF, 7'h7F, 4, 1'b1);
    add_hold(4'b1110, ~7'h01, 4, 1'b0);
    add_hold(4'hF, 7'h7F, 4, 1'b1);
    // Out-of-order digits, then a full scan.
    add_hold(4'b1110, gs(0), 4, 1'b0);
    add_hold(4'b1011, gs(7), 4, 1'b0);
    add_hold(4'b1110, gs(9), 4, 1'b1);
    add_hold(4'b1101, gs(10), 4, 1'b0);
    add_hold(4'b1011, gs(11), 4, 1'b0);
    add_hold(4'b0111, gs(12), 4, 1'b0);
    // Timeout on a long blank, then recovery.
    add_hold(4'hF, 7'h7F, 1100, 1'b0);
    add_hold(4'b1110, gs(13), 4, 1'b0);
    // Error and clear landing on the same edge, then a plain clear.
    add_hold(4'b1100, gs(1), 3, 1'b0);
    add_hold(4'hF, 7'h7F, 4, 1'b1);
    add_hold(4'hF, 7'h00, 4, 1'b1);
    // Randomized holds, biased toward in-order scanning.
    nk = 0;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        if ($urandom_range(0, 99) < 60) r = nk;
        else r = $urandom_range(0, 3);
        rs = ~(4'b0001 << r);
        nk = (r + 1) % 4;
      end else if (r < 85) begin
        rs = 4'hF;
      end else begin
        rs = 4'($urandom_range(0, 15));
      end
      add_hold(rs, ($urandom_range(0, 99) < 85) ? gs($urandom_range(0, 15))
                                                : 7'($urandom_range(0, 127)),
               $urandom_range(1, 5), $urandom_range(0, 9) == 0);
    end
    // Final long blank so the run ends in timeout.
    add_hold(4'hF, 7'h7F, 1100, 1'b0);

    run_model();

    repeat (R) @(posedge clk);
    #1;
    rst = 1'b0;
    tests++;
    if ({o_frameValid, o_badSelect, o_badPattern, o_seqErr, o_stale, o_digitValid, o_digits} !== 25'h0) begin
      fails++;
      $display("FAIL reset_state: got %h, expected 0",
               {o_frameValid, o_badSelect, o_badPattern, o_seqErr, o_stale, o_digitValid, o_digits});
    end
    mon_en = 1'b1;

    for (int i = 0; i < s_h.size(); i++) begin
      sel = s_sel[i];
      seg = s_seg[i];
      clr = s_clr[i];
      @(posedge clk);
      #1;
      clr = 1'b0;
      repeat (s_h[i] - 1) begin
        @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    #2;
    mon_en = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_changes: got %0d unseen, expected 0", exp_q.size());
    end
    tests++;
    if (o_stale !== m_stale || o_digits !== m_dig) begin
      fails++;
      $display("FAIL final_state: got stale=%b digits=%h, expected stale=%b digits=%h",
               o_stale, o_digits, m_stale, m_dig);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
